// File: rtl/sample_loader.sv
// Splits 32-bit receiver words into 16-bit samples and writes them into Bank I as ping-pong frames.
// Optional macro LOADER_OVF_DROP_EN: drop words when no buffer is free and count them on ovf_cnt.
module sample_loader #(
    parameter int ADDR_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_addr_1,
    output logic [15:0]       write_data_1,
    output logic              write_en_1,
    output logic              frame_valid,
    output logic              frame_sel,
    output logic [ADDR_W-1:0] frame_base,
    input  logic              frame_ack
`ifdef LOADER_OVF_DROP_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    localparam int PTR_W = $clog2(FRAME_LEN);
    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BASE_ADDR + FRAME_LEN);
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    state_t            state, state_n;
    logic [15:0]       hold_hi, hold_hi_n;
    logic [PTR_W-1:0]  wptr, wptr_n;
    logic              fill_sel, fill_sel_n;
    logic              rd_sel, rd_sel_n;
    logic [1:0]        full, full_n;
    logic [ADDR_W-1:0] addr_n;
    logic [15:0]       data_n;
    logic              we_n;
    logic              fv_n;
    logic              buf_free;
    logic              accept;
    logic              ack_take;
    logic [ADDR_W-1:0] fill_base;

    assign buf_free   = !full[fill_sel];
    assign fill_base  = fill_sel ? BASE1 : BASE0;
    assign ack_take   = frame_ack && frame_valid;
    assign frame_sel  = rd_sel;
    assign frame_base = rd_sel ? BASE1 : BASE0;

`ifdef LOADER_OVF_DROP_EN
    logic drop;
    assign in_ready = rst_n && (state != S_LO);
    assign accept   = in_valid && in_ready && buf_free;
    assign drop     = in_valid && in_ready && !buf_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt <= 16'h0000;
        else if (drop && ovf_cnt != 16'hFFFF)
            ovf_cnt <= ovf_cnt + 16'h0001;
    end
`else
    assign in_ready = rst_n && (state != S_LO) && buf_free;
    assign accept   = in_valid && in_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // The write port is registered: the low sample is issued on the accepting edge,
    // the high sample on the following edge, so S_LO/S_HI name what is on the port.
    always_comb begin
        state_n    = state;
        hold_hi_n  = hold_hi;
        wptr_n     = wptr;
        fill_sel_n = fill_sel;
        rd_sel_n   = rd_sel;
        full_n     = full;
        addr_n     = write_addr_1;
        data_n     = write_data_1;
        we_n       = 1'b0;

        case (state)
            S_LO: begin
                we_n    = 1'b1;
                addr_n  = fill_base + ADDR_W'(wptr);
                data_n  = hold_hi;
                state_n = S_HI;
                if (wptr == LAST) begin
                    wptr_n           = '0;
                    full_n[fill_sel] = 1'b1;
                    fill_sel_n       = !fill_sel;
                end else begin
                    wptr_n = wptr + PTR_W'(1);
                end
            end
            default: begin
                if (accept) begin
                    we_n      = 1'b1;
                    addr_n    = fill_base + ADDR_W'(wptr);
                    data_n    = in_data[15:0];
                    hold_hi_n = in_data[31:16];
                    wptr_n    = wptr + PTR_W'(1);
                    state_n   = S_LO;
                end else begin
                    state_n = S_IDLE;
                end
            end
        endcase

        // Completion and ack touch different buffers, so both always apply.
        if (ack_take) begin
            full_n[rd_sel] = 1'b0;
            rd_sel_n       = !rd_sel;
        end

        fv_n = ack_take ? 1'b0 : full[rd_sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_hi      <= 16'h0000;
            wptr         <= '0;
            fill_sel     <= 1'b0;
            rd_sel       <= 1'b0;
            full         <= 2'b00;
            write_addr_1 <= '0;
            write_data_1 <= 16'h0000;
            write_en_1   <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            hold_hi      <= hold_hi_n;
            wptr         <= wptr_n;
            fill_sel     <= fill_sel_n;
            rd_sel       <= rd_sel_n;
            full         <= full_n;
            write_addr_1 <= addr_n;
            write_data_1 <= data_n;
            write_en_1   <= we_n;
            frame_valid  <= fv_n;
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// Directed self-checking bench for sample_loader (FRAME_LEN=256, BASE_ADDR=0).
module tb_sample_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] write_addr_1;
    logic [15:0] write_data_1;
    logic        write_en_1;
    logic        frame_valid;
    logic        frame_sel;
    logic [15:0] frame_base;
    logic        frame_ack = 1'b0;
`ifdef LOADER_OVF_DROP_EN
    logic [15:0] ovf_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    sample_loader #(.ADDR_W(16), .FRAME_LEN(256), .BASE_ADDR(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .write_addr_1(write_addr_1),
        .write_data_1(write_data_1),
        .write_en_1(write_en_1),
        .frame_valid(frame_valid),
        .frame_sel(frame_sel),
        .frame_base(frame_base),
        .frame_ack(frame_ack)
`ifdef LOADER_OVF_DROP_EN
        ,
        .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        frame_ack = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Word k carries samples 2k (low) and 2k+1 (high), so data equals the sample index.
    task automatic stream_words(input int n, input int first);
        int acc = 0;
        int cyc = 0;
        bit took;
        while (acc < n && cyc < 2 * n + 20) begin
            in_valid = 1'b1;
            in_data = {16'(2 * (first + acc) + 1), 16'(2 * (first + acc))};
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) acc++;
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (acc != n) begin
            miscompares++;
            $display("[TB] FAIL stream_accept: accepted %0d words, required %0d", acc, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        #3;
        vectors += 7;
        if (write_en_1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b want 0", write_en_1); end
        if (write_addr_1 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h want 0", write_addr_1); end
        if (write_data_1 !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", write_data_1); end
        if (frame_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fv: got %b want 0", frame_valid); end
        if (frame_sel !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sel: got %b want 0", frame_sel); end
        if (frame_base !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_base: got %h want 0", frame_base); end
        if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_single_word;
        do_reset();
        in_valid = 1'b1;
        in_data = 32'hBEEF_1234;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (write_en_1 !== 1'b1 || write_addr_1 !== 16'd0 || write_data_1 !== 16'h1234) begin
            miscompares++;
            $display("[TB] FAIL single_lo: got en=%b addr=%h data=%h want en=1 addr=0000 data=1234", write_en_1, write_addr_1, write_data_1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (write_en_1 !== 1'b1 || write_addr_1 !== 16'd1 || write_data_1 !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_hi: got en=%b addr=%h data=%h want en=1 addr=0001 data=beef", write_en_1, write_addr_1, write_data_1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (write_en_1 !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle: got en=%b want 0", write_en_1); end
    endtask

    task automatic test_stream_frame;
        int nacc = 0;
        int nwr = 0;
        int cyc = 0;
        int first_cyc = -1;
        int last_cyc = 0;
        bit took;
        bit saw_last = 1'b0;
        do_reset();
        while (nwr < 258 && cyc < 800) begin
            in_valid = (nacc < 129);
            in_data = {16'(2 * nacc + 1), 16'(2 * nacc)};
            @(negedge clk);
            took = in_valid && in_ready;
            if (saw_last) begin
                vectors++;
                if (frame_valid !== 1'b1 || frame_sel !== 1'b0 || frame_base !== 16'h0) begin
                    miscompares++;
                    $display("[TB] FAIL stream_frame_valid: got fv=%b sel=%b base=%h want fv=1 sel=0 base=0000", frame_valid, frame_sel, frame_base);
                end
                saw_last = 1'b0;
            end
            if (write_en_1) begin
                vectors++;
                if (write_addr_1 !== nwr[15:0] || write_data_1 !== nwr[15:0]) begin
                    miscompares++;
                    $display("[TB] FAIL stream_write: got addr=%h data=%h want addr=%h data=%h", write_addr_1, write_data_1, nwr[15:0], nwr[15:0]);
                end
                if (nwr == 255) begin
                    vectors++;
                    if (frame_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_fv_early: got %b want 0", frame_valid); end
                    saw_last = 1'b1;
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nwr++;
            end
            @(posedge clk);
            #1;
            if (took) nacc++;
            cyc++;
        end
        in_valid = 1'b0;
        vectors += 2;
        if (nwr != 258) begin miscompares++; $display("[TB] FAIL stream_count: got %0d writes want 258", nwr); end
        if (last_cyc - first_cyc != 257) begin miscompares++; $display("[TB] FAIL stream_gapless: got span %0d want 257", last_cyc - first_cyc); end
    endtask

    task automatic test_backpressure;
        do_reset();
        stream_words(256, 0);
        in_valid = 1'b1;
        in_data = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors += 2;
            if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready: got %b want 0", in_ready); end
            if (write_en_1 !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_write: got %b want 0", write_en_1); end
        end
        vectors++;
        if (frame_valid !== 1'b1 || frame_sel !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_frame0: got fv=%b sel=%b want fv=1 sel=0", frame_valid, frame_sel);
        end
        @(posedge clk);
        #1;
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        vectors++;
        if (frame_sel !== 1'b1 || frame_base !== 16'd256 || frame_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_after_ack: got sel=%b base=%h fv=%b ready=%b want sel=1 base=0100 fv=0 ready=1", frame_sel, frame_base, frame_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (write_en_1 !== 1'b1 || write_addr_1 !== 16'd0 || write_data_1 !== 16'hF00D || frame_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_resume: got en=%b addr=%h data=%h fv=%b want en=1 addr=0000 data=f00d fv=1", write_en_1, write_addr_1, write_data_1, frame_valid);
        end
    endtask

    task automatic test_coincident;
        do_reset();
        stream_words(255, 0);
        stream_words(1, 255);
        frame_ack = 1'b1;
        vectors++;
        if (write_en_1 !== 1'b1 || write_addr_1 !== 16'd510 || frame_valid !== 1'b1 || frame_sel !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL coin_setup: got en=%b addr=%h fv=%b sel=%b want en=1 addr=01fe fv=1 sel=0", write_en_1, write_addr_1, frame_valid, frame_sel);
        end
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        vectors += 2;
        if (frame_sel !== 1'b1 || frame_base !== 16'd256 || write_addr_1 !== 16'd511) begin
            miscompares++;
            $display("[TB] FAIL coin_sel: got sel=%b base=%h addr=%h want sel=1 base=0100 addr=01ff", frame_sel, frame_base, write_addr_1);
        end
        if (dut.full !== 2'b10) begin miscompares++; $display("[TB] FAIL coin_full: got %b want 10", dut.full); end
        @(posedge clk);
        #1;
        vectors++;
        if (frame_valid !== 1'b1 || frame_sel !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL coin_present: got fv=%b sel=%b ready=%b want fv=1 sel=1 ready=1", frame_valid, frame_sel, in_ready);
        end
    endtask

    task automatic test_spurious_ack_reset;
        do_reset();
        stream_words(3, 0);
        repeat (2) @(posedge clk);
        #1;
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        vectors++;
        if (frame_valid !== 1'b0 || frame_sel !== 1'b0 || frame_base !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL spur_frame: got fv=%b sel=%b base=%h want fv=0 sel=0 base=0000", frame_valid, frame_sel, frame_base);
        end
        stream_words(1, 3);
        vectors++;
        if (write_en_1 !== 1'b1 || write_addr_1 !== 16'd6 || write_data_1 !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL spur_next: got en=%b addr=%h data=%h want en=1 addr=0006 data=0006", write_en_1, write_addr_1, write_data_1);
        end
        stream_words(46, 4);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (write_en_1 !== 1'b0 || write_addr_1 !== 16'h0 || write_data_1 !== 16'h0 || frame_valid !== 1'b0
            || frame_sel !== 1'b0 || frame_base !== 16'h0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got en=%b addr=%h data=%h fv=%b sel=%b base=%h ready=%b want all zero",
                     write_en_1, write_addr_1, write_data_1, frame_valid, frame_sel, frame_base, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (write_en_1 !== 1'b1 || write_addr_1 !== 16'd0 || write_data_1 !== 16'hAAAA) begin
            miscompares++;
            $display("[TB] FAIL midreset_restart: got en=%b addr=%h data=%h want en=1 addr=0000 data=aaaa", write_en_1, write_addr_1, write_data_1);
        end
    endtask

`ifdef LOADER_OVF_DROP_EN
    task automatic test_ovf_drop;
        int writes = 0;
        do_reset();
        stream_words(256, 0);
        repeat (3) @(posedge clk);
        #1;
        in_data = 32'h1111_2222;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            @(negedge clk);
            if (write_en_1) writes++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors += 3;
        if (writes != 0) begin miscompares++; $display("[TB] FAIL ovf_writes: got %0d want 0", writes); end
        if (ovf_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL ovf_cnt: got %0d want 3", ovf_cnt); end
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_ready: got %b want 1", in_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_stream_frame();
        test_backpressure();
        test_coincident();
        test_spurious_ack_reset();
`ifdef LOADER_OVF_DROP_EN
        test_ovf_drop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
